// File: rtl/xcorr_lag_scan.sv
// rtl/xcorr_lag_scan.sv - circular-lag correlation peak search, NPAR lags per clock
module xcorr_lag_scan #(
    parameter  int NDATA = 128,
    parameter  int NLAG  = 16,
    parameter  int NPAR  = 4,
    localparam int SW    = $clog2(NDATA) + 1,
    localparam int LW    = (NLAG > 1) ? $clog2(NLAG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NDATA-1:0] din_ref,
    input  logic [NDATA-1:0] din_sig,
    input  logic [SW-1:0]    thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW-1:0]    best_lag,
    output logic [SW-1:0]    best_score,
    output logic             detect
);

    localparam int NG = NLAG / NPAR;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((NLAG % NPAR) != 0) begin : g_bad_npar
            $error("xcorr_lag_scan: NLAG must be a multiple of NPAR");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [NDATA-1:0] ref_q, ref_d;
    logic [NDATA-1:0] work_q, work_d;
    logic [SW-1:0]    thresh_q, thresh_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic [LW-1:0]    best_lag_q, best_lag_d;
    logic [SW-1:0]    best_score_q, best_score_d;
    logic             detect_q, detect_d;

    function automatic logic [SW-1:0] match_count(input logic [NDATA-1:0] a,
                                                   input logic [NDATA-1:0] b);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < NDATA; i++) begin
            c = c + SW'(~(a[i] ^ b[i]));
        end
        return c;
    endfunction

    // The doubled word lets every left rotation be a constant slice.
    logic [2*NDATA-1:0] work_dbl;
    logic [SW-1:0]      pscore [NPAR];

    assign work_dbl = {work_q, work_q};

    generate
        for (genvar p = 0; p < NPAR; p++) begin : g_lane
            assign pscore[p] = match_count(ref_q, work_dbl[2*NDATA-1-p -: NDATA]);
        end
    endgenerate

    logic [SW-1:0] gbest_score;
    int            gbest_off;
    logic [LW-1:0] gbest_lag;

    // Strict compare in ascending lane order keeps the lowest lag on ties.
    always_comb begin
        gbest_score = pscore[0];
        gbest_off   = 0;
        for (int p = 1; p < NPAR; p++) begin
            if (pscore[p] > gbest_score) begin
                gbest_score = pscore[p];
                gbest_off   = p;
            end
        end
        gbest_lag = LW'(int'(grp_q) * NPAR + gbest_off);
    end

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        work_d       = work_q;
        thresh_d     = thresh_q;
        grp_d        = grp_q;
        best_lag_d   = best_lag_q;
        best_score_d = best_score_q;
        detect_d     = detect_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ref_d    = din_ref;
                    work_d   = din_sig;
                    thresh_d = thresh;
                    grp_d    = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                work_d = work_dbl[2*NDATA-1-NPAR -: NDATA];
                grp_d  = grp_q + GW'(1);
                if ((grp_q == '0) || (gbest_score > best_score_q)) begin
                    best_lag_d   = gbest_lag;
                    best_score_d = gbest_score;
                end
                if (grp_q == GW'(NG - 1)) begin
                    detect_d = (best_score_d >= thresh_q);
                    grp_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ref_q        <= '0;
            work_q       <= '0;
            thresh_q     <= '0;
            grp_q        <= '0;
            best_lag_q   <= '0;
            best_score_q <= '0;
            detect_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            work_q       <= work_d;
            thresh_q     <= thresh_d;
            grp_q        <= grp_d;
            best_lag_q   <= best_lag_d;
            best_score_q <= best_score_d;
            detect_q     <= detect_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign best_lag   = best_lag_q;
    assign best_score = best_score_q;
    assign detect     = detect_q;

endmodule

// File: doc/xcorr_lag_scan.md
Name: xcorr_lag_scan

Overview:
Parametrised successor to the fixed four-lag correlator array. It searches NLAG circular lags of a signal word against a reference word, NPAR lags per clock. It tracks the peak match count and its lag, and reports the winner with a threshold-detect flag over a valid/ready handshake. It sits between the capture buffer and the sync/alignment controller.

Parameters:
NDATA, 128, bit width of reference and signal words (>= 4)
NLAG, 16, number of lags searched, 0..NLAG-1 (1 <= NLAG <= NDATA)
NPAR, 4, lags evaluated per clock; NLAG % NPAR must be 0, otherwise elaboration error
SW, $clog2(NDATA)+1, score width (derived)
LW, max(1,$clog2(NLAG)), lag index width (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job request
in_ready  out  1  block idle and accepting a job
din_ref  in  NDATA  reference word
din_sig  in  NDATA  signal word
thresh  in  SW  detect threshold, sampled with the job
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
best_lag  out  LW  lag index of the peak
best_score  out  SW  peak match count
detect  out  1  best_score >= sampled thresh

Behaviour:
- Score(k) = popcount(~(din_ref ^ rotl(din_sig,k))), where rotl by 1 = {sig[NDATA-2:0], sig[NDATA-1]}. Range 0..NDATA; SW bits, no saturation needed.
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; best_lag=0; best_score=0; detect=0; internal ref/sig/thresh/group counter cleared. Any job in progress is abandoned with no output.
- IDLE: in_ready=1. At an edge with in_valid=1:
  - register din_ref, din_sig, thresh
  - group counter g=0
  - go to SCAN
- SCAN: in_ready=0, out_valid=0.
  - Each cycle, score lags g*NPAR .. g*NPAR+NPAR-1 combinationally from a working signal register holding rotl(sig, g*NPAR).
  - At each edge the working register rotates left by NPAR and g increments.
  - Best update: group 0 loads unconditionally. Later groups replace the running best only if strictly greater.
  - Within a group the lowest lag wins ties. Net effect: global ties resolve to the smallest lag.
  - At the edge where g = NLAG/NPAR-1, commit the final best and detect, then go to DONE.
- DONE: out_valid=1, in_ready=0. best_lag, best_score and detect are held stable while out_ready=0.
  - At an edge with out_valid & out_ready: go to IDLE and clear out_valid.
  - Results stay held (not cleared) until the next job's group 0.
- Latency: out_valid rises NLAG/NPAR cycles after the acceptance edge (defaults: 4).
  - Minimum job period is NLAG/NPAR+2 cycles.
  - No overlap between jobs; in_valid during SCAN/DONE is ignored, not queued.
- in_valid & out_ready together in DONE: only the result handshake occurs. The new job is accepted in IDLE on a later edge.
- NLAG=NPAR: single SCAN cycle.
- detect is evaluated only from the final best; thresh=0 gives detect=1 always.

Test Plan:
(Defaults: NDATA=128, NLAG=16, NPAR=4.)
1. ref = 128-bit LFSR word, sig = ref -> best_lag=0, best_score=128, detect=1 (thresh=100); out_valid exactly 4 cycles after acceptance edge.
2. ref = LFSR word, sig = rotr(ref,9) -> best_lag=9, best_score=128. Repeat with rotr by 15 -> best_lag=15 (last lag of last group).
3. ref = all zeros, sig = all zeros -> every score 128, tie -> best_lag=0, best_score=128.
4. ref = all zeros, sig = all ones, thresh=1 -> best_lag=0, best_score=0, detect=0. Rerun with thresh=0 -> detect=1.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> out_valid low and in_ready high next cycle; the following job returns correct results.
6. Assert rst_n=0 for 1 cycle during SCAN (g=2) -> out_valid=0, in_ready=1, best_score=0 immediately (asynchronous). The next job from case 2 returns best_lag=9.
